// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first, for a WIDTH-bit operation.
// Optional build macro ALU_SERIAL_OVF_EN enables the overflow flag and overflow-corrected slt.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [5:0]       slice_ctl,
  output logic             slice_ai,
  output logic             slice_bi,
  output logic             slice_invb,
  output logic             slice_cin,
  input  logic             slice_sum,
  input  logic             slice_cout,
  input  logic             slice_set
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [5:0] CTL_ADD = 6'd32;
  localparam logic [5:0] CTL_SUB = 6'd34;
  localparam logic [5:0] CTL_AND = 6'd36;
  localparam logic [5:0] CTL_OR  = 6'd37;
  localparam logic [5:0] CTL_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [5:0]       ctl_q;
  logic             invb_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic             invb_cap;
  logic             legal;
  logic             last_bit;
  logic             less;
  logic [WIDTH-1:0] sum_word;
  logic [WIDTH-1:0] final_word;

  // Slice inputs come straight from flops so the slice round trip is the only comb path per cycle.
  assign slice_ctl  = ctl_q;
  assign slice_ai   = a_sh[0];
  assign slice_bi   = b_sh[0];
  assign slice_invb = invb_q;
  assign slice_cin  = carry_q;

  assign invb_cap = (ctl == CTL_SUB) || (ctl == CTL_SLT);
  assign legal    = (ctl_q == CTL_ADD) || (ctl_q == CTL_SUB) || (ctl_q == CTL_AND) ||
                    (ctl_q == CTL_OR)  || (ctl_q == CTL_SLT);
  assign last_bit = (state_q == RUN) && (idx_q == LAST);

  // Operand A is shifted out at the bottom while sum bits shift in at the top.
  assign sum_word = {slice_sum, a_sh[WIDTH-1:1]};

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_bit;
  logic is_arith;
  assign ovf_bit  = slice_cin ^ slice_cout;
  assign is_arith = (ctl_q == CTL_ADD) || (ctl_q == CTL_SUB);
  assign less     = slice_set ^ ovf_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (last_bit) begin
      overflow <= is_arith & ovf_bit;
    end
  end
`else
  assign less     = slice_set;
  assign overflow = 1'b0;
`endif

  assign final_word = (ctl_q == CTL_SLT) ? {{(WIDTH-1){1'b0}}, less} : sum_word;

  // NOTE: every flop here, including the operand shift registers, takes the async reset and is
  // written with non-blocking assignments so all next-state terms see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      ctl_q   <= '0;
      invb_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            ctl_q   <= ctl;
            invb_q  <= invb_cap;
            carry_q <= invb_cap;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= sum_word;
          b_sh    <= b_sh >> 1;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IW'(1);
          if (last_bit) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= final_word;
            zero    <= (final_word == '0);
            illegal <= !legal;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: behavioural 1-bit slice, word-level reference model,
// directed and randomized operations, back-to-back issue, ignored starts and mid-run reset.
module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;

  localparam logic [5:0] C_ADD = 6'd32;
  localparam logic [5:0] C_SUB = 6'd34;
  localparam logic [5:0] C_AND = 6'd36;
  localparam logic [5:0] C_OR  = 6'd37;
  localparam logic [5:0] C_SLT = 6'd42;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [5:0]       ctl_in = '0;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;

  logic             busy, done, zero, overflow, illegal;
  logic [WIDTH-1:0] result;
  logic [5:0]       slice_ctl;
  logic             slice_ai, slice_bi, slice_invb, slice_cin;
  logic             slice_sum, slice_cout, slice_set;
  logic             s_bb, s_add;

  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] held_r = '0;
  logic             exp_o, exp_il;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctl(ctl_in), .a(a_in), .b(b_in),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow),
    .illegal(illegal), .slice_ctl(slice_ctl), .slice_ai(slice_ai), .slice_bi(slice_bi),
    .slice_invb(slice_invb), .slice_cin(slice_cin), .slice_sum(slice_sum),
    .slice_cout(slice_cout), .slice_set(slice_set)
  );

  // Behavioural 1-bit ALU slice; unknown codes return a^b so illegal ops are predictable.
  assign s_bb       = slice_bi ^ slice_invb;
  assign s_add      = slice_ai ^ s_bb ^ slice_cin;
  assign slice_cout = (slice_ai & s_bb) | (slice_ai & slice_cin) | (s_bb & slice_cin);
  assign slice_set  = s_add;

  always_comb begin
    slice_sum = 1'b0;
    case (slice_ctl)
      C_ADD, C_SUB: slice_sum = s_add;
      C_AND:        slice_sum = slice_ai & slice_bi;
      C_OR:         slice_sum = slice_ai | slice_bi;
      C_SLT:        slice_sum = 1'b0;
      default:      slice_sum = slice_ai ^ slice_bi;
    endcase
  end

  function automatic void model(input logic [5:0] c, input logic [WIDTH-1:0] x, y,
                                output logic [WIDTH-1:0] r, output logic o, output logic il);
    logic [WIDTH-1:0] d;
    logic             lt;
    d  = x - y;
    r  = '0;
    o  = 1'b0;
    il = 1'b0;
`ifdef ALU_SERIAL_OVF_EN
    lt = $signed(x) < $signed(y);
`else
    lt = d[WIDTH-1];
`endif
    case (c)
      C_ADD: begin
        r = x + y;
        o = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      C_SUB: begin
        r = d;
        o = (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
      end
      C_AND:   r = x & y;
      C_OR:    r = x | y;
      C_SLT:   r = {{(WIDTH-1){1'b0}}, lt};
      default: begin
        r  = x ^ y;
        il = 1'b1;
      end
    endcase
`ifndef ALU_SERIAL_OVF_EN
    o = 1'b0;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] rand_ctl();
    logic [5:0] c;
    case ($urandom_range(0, 6))
      0:       c = C_ADD;
      1:       c = C_SUB;
      2:       c = C_AND;
      3:       c = C_OR;
      4, 5:    c = C_SLT;
      default: begin
        c = 6'($urandom);
        if (c == C_ADD || c == C_SUB || c == C_AND || c == C_OR || c == C_SLT) c = 6'd63;
      end
    endcase
    return c;
  endfunction

  // Called at a negedge; returns just after the accepting edge with inputs scrambled.
  task automatic issue(input logic [5:0] c, input logic [WIDTH-1:0] x, y);
    ctl_in = c;
    a_in   = x;
    b_in   = y;
    start  = 1'b1;
    model(c, x, y, exp_r, exp_o, exp_il);
    @(posedge clk);
    #1;
    start  = 1'b0;
    ctl_in = 6'($urandom);
    a_in   = $urandom;
    b_in   = $urandom;
  endtask

  // Returns at the negedge where done is seen, so a caller may issue back-to-back from there.
  task automatic wait_done(input string name, input bit poke);
    int n;
    bit seen;
    bit run_ok;
    n = 0;
    seen = 1'b0;
    run_ok = 1'b1;
    while (!seen && n < WIDTH + 20) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1 || result !== held_r) run_ok = 1'b0;
        if (poke) begin
          start = (n >= 3 && n <= 10);
          if (start) begin
            a_in   = $urandom;
            b_in   = $urandom;
            ctl_in = C_OR;
          end
        end
      end
    end
    tests++;
    if (!seen || n != WIDTH + 1) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles (done seen=%0b), want %0d", name, n, seen, WIDTH + 1);
    end
    tests++;
    if (!run_ok) begin
      fails++;
      $display("FAIL %s run: busy low or result not held during run (held %h)", name, held_r);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy_with_done: got %b, want 0", name, busy);
    end
    tests++;
    if (result !== exp_r) begin
      fails++;
      $display("FAIL %s result: got %h, want %h", name, result, exp_r);
    end
    tests++;
    if (zero !== (exp_r == '0)) begin
      fails++;
      $display("FAIL %s zero: got %b, want %b", name, zero, (exp_r == '0));
    end
    tests++;
    if (overflow !== exp_o) begin
      fails++;
      $display("FAIL %s overflow: got %b, want %b", name, overflow, exp_o);
    end
    tests++;
    if (illegal !== exp_il) begin
      fails++;
      $display("FAIL %s illegal: got %b, want %b", name, illegal, exp_il);
    end
    held_r = exp_r;
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if ({busy, done, zero, overflow, illegal} !== 5'b00100) begin
      fails++;
      $display("FAIL %s flags: got busy/done/zero/ovf/ill=%b, want 00100",
               name, {busy, done, zero, overflow, illegal});
    end
    tests++;
    if (result !== '0) begin
      fails++;
      $display("FAIL %s result: got %h, want 0", name, result);
    end
    tests++;
    if ({slice_ctl, slice_ai, slice_bi, slice_invb, slice_cin} !== 10'b0) begin
      fails++;
      $display("FAIL %s slice outputs: got %b, want 0", name,
               {slice_ctl, slice_ai, slice_bi, slice_invb, slice_cin});
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    held_r = '0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    issue(C_ADD, 32'd5, 32'd7);
    wait_done("add_5_7", 1'b0);
    issue(C_SUB, 32'h1234, 32'h1234);
    wait_done("sub_equal", 1'b0);
    issue(C_ADD, 32'h7FFF_FFFF, 32'd1);
    wait_done("add_ovf", 1'b0);
    issue(C_SLT, 32'h8000_0000, 32'd1);
    wait_done("slt_neg", 1'b0);
    issue(C_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    wait_done("slt_ovf", 1'b0);
    issue(C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_done("and", 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(C_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_done("or_b2b", 1'b0);
    issue(C_SUB, 32'd3, 32'd10);
    wait_done("sub_b2b", 1'b0);
  endtask

  task automatic test_ignore_start();
    issue(C_ADD, 32'h0001_0203, 32'h1000_0000);
    wait_done("ignore_start", 1'b1);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_start queued: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_illegal();
    issue(6'd39, 32'h0000_00FF, 32'h0000_0F0F);
    wait_done("illegal_39", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    bit stray;
    issue(6'd39, 32'd5, 32'd7);
    wait_done("pre_reset_illegal", 1'b0);
    issue(C_ADD, 32'h1111_1111, 32'h2222_2222);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    held_r = '0;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    tests++;
    if (stray) begin
      fails++;
      $display("FAIL mid_reset activity: busy or done seen while in reset, want none");
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(C_ADD, 32'd100, 32'd23);
    wait_done("after_reset_add", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(rand_ctl(), rand_op(), rand_op());
      wait_done($sformatf("rand_%0d", i), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_illegal();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
